// File: rtl/packet_pkg.sv
// Shared types and constants for the payload-path packet filter.
// Holds the filter FSM encoding, the debug view and the pass/drop decision rule.
package packet_pkg;

  localparam int MAC_W   = 48;
  localparam int ETYPE_W = 16;
  localparam logic [MAC_W-1:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    FLT_IDLE,
    FLT_HDR,
    FLT_PASS,
    FLT_DROP
  } filter_state_e;

  typedef struct packed {
    filter_state_e        state;
    logic [MAC_W-1:0]     src_mac;
    logic [ETYPE_W-1:0]   etype;
    logic                 err;
  } filter_dbg_t;

  function automatic logic filter_pass(input logic               en,
                                       input logic [MAC_W-1:0]   dst,
                                       input logic [MAC_W-1:0]   match_mac,
                                       input logic [ETYPE_W-1:0] etype,
                                       input logic [ETYPE_W-1:0] match_etype);
    return !en || (((dst == match_mac) || (dst == BROADCAST_MAC)) && (etype == match_etype));
  endfunction

endpackage

// File: rtl/packet_filter_if.sv
// Bundle of aligner-side inputs and forwarded-stream outputs of the packet filter.
// Handshake: every *_valid / strobe qualifies its data on that cycle only; there is
// no ready, so every valid beat or header is consumed the cycle it is presented.
interface packet_filter_if #(
  parameter int DATA_W = 64,
  parameter int BE_W   = 8,
  parameter int CNT_W  = 32
);
  import packet_pkg::*;

  logic [DATA_W-1:0]  iPayload;
  logic               iPayload_valid;
  logic [MAC_W-1:0]   iHeader_A;
  logic               iHeader_A_valid;
  logic [MAC_W-1:0]   iHeader_B;
  logic               iHeader_B_valid;
  logic [ETYPE_W-1:0] iHeader_C;
  logic               iHeader_C_valid;
  logic               iSop;
  logic               iEop;
  logic [BE_W-1:0]    iByte_enable;
  logic [MAC_W-1:0]   iMatch_mac;
  logic [ETYPE_W-1:0] iMatch_etype;
  logic               iFilter_en;

  logic [DATA_W-1:0]  oPayload;
  logic               oValid;
  logic               oSop;
  logic               oEop;
  logic [BE_W-1:0]    oByte_enable;
  logic [CNT_W-1:0]   oPass_cnt;
  logic [CNT_W-1:0]   oDrop_cnt;
  logic [CNT_W-1:0]   oErr_cnt;
  filter_dbg_t        oDbg;

  modport slave (
    input  iPayload, iPayload_valid, iHeader_A, iHeader_A_valid, iHeader_B, iHeader_B_valid,
           iHeader_C, iHeader_C_valid, iSop, iEop, iByte_enable, iMatch_mac, iMatch_etype,
           iFilter_en,
    output oPayload, oValid, oSop, oEop, oByte_enable, oPass_cnt, oDrop_cnt, oErr_cnt, oDbg
  );

  modport master (
    output iPayload, iPayload_valid, iHeader_A, iHeader_A_valid, iHeader_B, iHeader_B_valid,
           iHeader_C, iHeader_C_valid, iSop, iEop, iByte_enable, iMatch_mac, iMatch_etype,
           iFilter_en,
    input  oPayload, oValid, oSop, oEop, oByte_enable, oPass_cnt, oDrop_cnt, oErr_cnt, oDbg
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] value_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/packet_filter.sv
// Per-packet PASS/DROP filter on dst MAC + ethertype behind the payload aligner.
// Passed beats leave through one register stage; pass/drop/error packets are counted.
module packet_filter
  import packet_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int BE_W   = 8,
  parameter int CNT_W  = 32
) (
  input logic            iClk,
  input logic            iReset,
  packet_filter_if.slave bus
);

  filter_state_e      state_q, state_d;
  logic               err_q, err_d;
  logic               first_q, first_d;
  logic [MAC_W-1:0]   hdr_a_q, hdr_b_q;
  logic [ETYPE_W-1:0] hdr_c_q;

  logic [MAC_W-1:0]   dst_mac;
  logic               decide;
  logic               fwd, pass_inc, drop_inc, err_inc;

  logic               out_valid_q, out_valid_d;
  logic               out_sop_q, out_sop_d;
  logic               out_eop_q, out_eop_d;
  logic [BE_W-1:0]    out_be_q, out_be_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;

  // A strobe coincident with C must bypass the (still stale) header register.
  assign dst_mac = bus.iHeader_A_valid ? bus.iHeader_A : hdr_a_q;
  assign decide  = filter_pass(bus.iFilter_en, dst_mac, bus.iMatch_mac,
                               bus.iHeader_C, bus.iMatch_etype);

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    first_d  = first_q;
    fwd      = 1'b0;
    pass_inc = 1'b0;
    drop_inc = 1'b0;
    err_inc  = 1'b0;
    case (state_q)
      FLT_IDLE: begin
        if (bus.iSop) begin
          state_d = FLT_HDR;
          err_d   = 1'b0;
        end
      end
      FLT_HDR: begin
        if (bus.iSop) begin
          err_inc = 1'b1;
          err_d   = 1'b0;
        end else if (bus.iHeader_C_valid) begin
          if (bus.iEop) begin
            state_d  = FLT_IDLE;
            pass_inc = decide;
            drop_inc = !decide;
          end else begin
            state_d = decide ? FLT_PASS : FLT_DROP;
            first_d = 1'b1;
          end
        end else if (bus.iEop) begin
          err_inc = 1'b1;
          state_d = FLT_IDLE;
        end else if (bus.iPayload_valid) begin
          err_inc = 1'b1;
          err_d   = 1'b1;
          state_d = FLT_DROP;
        end
      end
      FLT_PASS: begin
        if (bus.iSop) begin
          err_inc = 1'b1;
          state_d = FLT_HDR;
        end else begin
          if (bus.iPayload_valid) begin
            fwd     = 1'b1;
            first_d = 1'b0;
          end
          if (bus.iEop) begin
            pass_inc = 1'b1;
            state_d  = FLT_IDLE;
          end
        end
      end
      FLT_DROP: begin
        // Errored packets were already counted when the error was seen.
        if (bus.iSop) begin
          err_inc = !err_q;
          err_d   = 1'b0;
          state_d = FLT_HDR;
        end else if (bus.iEop) begin
          drop_inc = !err_q;
          state_d  = FLT_IDLE;
        end
      end
      default: state_d = FLT_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = fwd;
    out_sop_d   = fwd && first_q;
    out_eop_d   = fwd && bus.iEop;
    out_be_d    = fwd ? bus.iByte_enable : '0;
    out_data_d  = fwd ? bus.iPayload : out_data_q;
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q     <= FLT_IDLE;
      err_q       <= 1'b0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_be_q    <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_be_q    <= out_be_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      hdr_a_q <= '0;
      hdr_b_q <= '0;
      hdr_c_q <= '0;
    end else begin
      if (bus.iHeader_A_valid) hdr_a_q <= bus.iHeader_A;
      if (bus.iHeader_B_valid) hdr_b_q <= bus.iHeader_B;
      if (bus.iHeader_C_valid) hdr_c_q <= bus.iHeader_C;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk_i(iClk), .rst_i(iReset), .inc_i(pass_inc), .value_o(bus.oPass_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk_i(iClk), .rst_i(iReset), .inc_i(drop_inc), .value_o(bus.oDrop_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk_i(iClk), .rst_i(iReset), .inc_i(err_inc), .value_o(bus.oErr_cnt)
  );

  assign bus.oPayload     = out_data_q;
  assign bus.oValid       = out_valid_q;
  assign bus.oSop         = out_sop_q;
  assign bus.oEop         = out_eop_q;
  assign bus.oByte_enable = out_be_q;
  assign bus.oDbg         = '{state: state_q, src_mac: hdr_b_q, etype: hdr_c_q, err: err_q};

endmodule

// File: tb/tb_packet_filter.sv
// Bench for packet_filter: directed packet table, corner sequences and random packets
// checked against a packet-level model; a CNT_W=4 copy shares the inputs for saturation.
module tb_packet_filter;
  import packet_pkg::*;

  localparam logic [47:0] MATCH_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [15:0] MATCH_ET  = 16'h0800;
  localparam logic [15:0] V6_ET     = 16'h86DD;
  localparam int K_NORMAL = 0, K_RUNT = 1, K_EARLY = 2, K_TRUNC = 3;
  localparam int EXP_W = 64 + 1 + 1 + 8 + 32;

  typedef struct {
    logic [47:0] dst;
    logic [15:0] et;
    bit          fen;
    int          nb;
    logic [7:0]  be_last;
    bit          a_with_c;
    bit          exp_pass;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int n_chk = 0, n_fail = 0;
  int pass_m = 0, drop_m = 0, err_m = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] obs_q[$];
  vec_t vecs[10];

  packet_filter_if #(.DATA_W(64), .BE_W(8), .CNT_W(32)) ifc ();
  packet_filter_if #(.DATA_W(64), .BE_W(8), .CNT_W(4))  ifc4 ();

  packet_filter #(.DATA_W(64), .BE_W(8), .CNT_W(32)) dut (.iClk(clk), .iReset(rst), .bus(ifc));
  packet_filter #(.DATA_W(64), .BE_W(8), .CNT_W(4))  dut4 (.iClk(clk), .iReset(rst), .bus(ifc4));

  assign ifc4.iPayload        = ifc.iPayload;
  assign ifc4.iPayload_valid  = ifc.iPayload_valid;
  assign ifc4.iHeader_A       = ifc.iHeader_A;
  assign ifc4.iHeader_A_valid = ifc.iHeader_A_valid;
  assign ifc4.iHeader_B       = ifc.iHeader_B;
  assign ifc4.iHeader_B_valid = ifc.iHeader_B_valid;
  assign ifc4.iHeader_C       = ifc.iHeader_C;
  assign ifc4.iHeader_C_valid = ifc.iHeader_C_valid;
  assign ifc4.iSop            = ifc.iSop;
  assign ifc4.iEop            = ifc.iEop;
  assign ifc4.iByte_enable    = ifc.iByte_enable;
  assign ifc4.iMatch_mac      = ifc.iMatch_mac;
  assign ifc4.iMatch_etype    = ifc.iMatch_etype;
  assign ifc4.iFilter_en      = ifc.iFilter_en;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  // Observed forwarded beats, stamped with the cycle they appeared.
  always @(negedge clk) begin
    if (ifc.oValid === 1'b1)
      obs_q.push_back({ifc.oPayload, ifc.oSop, ifc.oEop, ifc.oByte_enable, cyc});
  end

  // ---------------- reference model ----------------
  function automatic bit ref_pass(logic [47:0] dst, logic [15:0] et, bit fen);
    return !fen || (((dst == MATCH_MAC) || (dst == BCAST_MAC)) && (et == MATCH_ET));
  endfunction

  function automatic int sat4(int v);
    return (v > 15) ? 15 : v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    ifc.iSop            = 1'b0;
    ifc.iEop            = 1'b0;
    ifc.iPayload_valid  = 1'b0;
    ifc.iHeader_A_valid = 1'b0;
    ifc.iHeader_B_valid = 1'b0;
    ifc.iHeader_C_valid = 1'b0;
    ifc.iPayload        = {$urandom, $urandom};
    ifc.iByte_enable    = 8'($urandom);
    ifc.iHeader_A       = {16'($urandom), $urandom};
    ifc.iHeader_B       = {16'($urandom), $urandom};
    ifc.iHeader_C       = 16'($urandom);
  endtask

  task automatic send_pkt(input logic [47:0] dst, input logic [15:0] et, input int nb,
                          input logic [7:0] be_last, input bit a_with_c, input int kind,
                          input bit dec);
    bit fwd;
    bit last;
    logic [7:0] be;
    fwd = dec && ((kind == K_NORMAL) || (kind == K_TRUNC));
    tick(); clear(); ifc.iSop = 1'b1;
    if (!a_with_c) begin
      tick(); clear(); ifc.iHeader_A = dst; ifc.iHeader_A_valid = 1'b1;
    end
    tick(); clear(); ifc.iHeader_B_valid = 1'b1;
    if (kind == K_RUNT) begin
      tick(); clear(); ifc.iEop = 1'b1;
    end else begin
      if (kind == K_EARLY) begin
        tick(); clear(); ifc.iPayload_valid = 1'b1;
      end
      tick(); clear();
      ifc.iHeader_C = et; ifc.iHeader_C_valid = 1'b1;
      if (a_with_c) begin
        ifc.iHeader_A = dst; ifc.iHeader_A_valid = 1'b1;
      end
      if ((nb == 0) && (kind != K_TRUNC)) ifc.iEop = 1'b1;
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 3) == 0) begin tick(); clear(); end
        tick(); clear();
        last = (i == nb - 1) && (kind != K_TRUNC);
        be = last ? be_last : ifc.iByte_enable;
        ifc.iByte_enable   = be;
        ifc.iPayload_valid = 1'b1;
        ifc.iEop           = last;
        if (fwd) exp_q.push_back({ifc.iPayload, (i == 0), last, be, cyc + 1});
      end
    end
    tick(); clear();
    if (kind == K_NORMAL) begin
      if (dec) pass_m++;
      else     drop_m++;
    end else begin
      err_m++;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    tick(); tick();
    @(negedge clk);
    chk({tag, ".pass_cnt"}, ifc.oPass_cnt, pass_m);
    chk({tag, ".drop_cnt"}, ifc.oDrop_cnt, drop_m);
    chk({tag, ".err_cnt"},  ifc.oErr_cnt,  err_m);
    chk({tag, ".pass_cnt4"}, ifc4.oPass_cnt, sat4(pass_m));
    chk({tag, ".drop_cnt4"}, ifc4.oDrop_cnt, sat4(drop_m));
    chk({tag, ".err_cnt4"},  ifc4.oErr_cnt,  sat4(err_m));
    chk({tag, ".state"}, ifc.oDbg.state, FLT_IDLE);
    chk({tag, ".beats"}, obs_q.size(), exp_q.size());
    while ((exp_q.size() > 0) && (obs_q.size() > 0))
      chk({tag, ".beat"}, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, ".valid"}, ifc.oValid, 1'b0);
    chk({tag, ".sop"}, ifc.oSop, 1'b0);
    chk({tag, ".eop"}, ifc.oEop, 1'b0);
    chk({tag, ".payload"}, ifc.oPayload, 64'h0);
    chk({tag, ".be"}, ifc.oByte_enable, 8'h0);
    chk({tag, ".pass_cnt"}, ifc.oPass_cnt, 32'h0);
    chk({tag, ".drop_cnt"}, ifc.oDrop_cnt, 32'h0);
    chk({tag, ".err_cnt"}, ifc.oErr_cnt, 32'h0);
    chk({tag, ".drop_cnt4"}, ifc4.oDrop_cnt, 4'h0);
    chk({tag, ".state"}, ifc.oDbg.state, FLT_IDLE);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [47:0] dst;
    logic [15:0] et;
    bit fen;
    int kind;

    vecs[0] = '{dst: MATCH_MAC, et: MATCH_ET, fen: 1, nb: 3, be_last: 8'h0F, a_with_c: 0, exp_pass: 1};
    vecs[1] = '{dst: MATCH_MAC, et: V6_ET,    fen: 1, nb: 3, be_last: 8'h0F, a_with_c: 0, exp_pass: 0};
    vecs[2] = '{dst: MATCH_MAC, et: V6_ET,    fen: 0, nb: 2, be_last: 8'hFF, a_with_c: 0, exp_pass: 1};
    vecs[3] = '{dst: BCAST_MAC, et: MATCH_ET, fen: 1, nb: 2, be_last: 8'h03, a_with_c: 0, exp_pass: 1};
    vecs[4] = '{dst: MATCH_MAC, et: V6_ET,    fen: 0, nb: 0, be_last: 8'h00, a_with_c: 0, exp_pass: 1};
    vecs[5] = '{dst: OTHER_MAC, et: MATCH_ET, fen: 1, nb: 2, be_last: 8'h01, a_with_c: 0, exp_pass: 0};
    vecs[6] = '{dst: MATCH_MAC, et: MATCH_ET, fen: 1, nb: 1, be_last: 8'h7F, a_with_c: 1, exp_pass: 1};
    vecs[7] = '{dst: OTHER_MAC, et: MATCH_ET, fen: 1, nb: 2, be_last: 8'hFF, a_with_c: 1, exp_pass: 0};
    vecs[8] = '{dst: BCAST_MAC, et: V6_ET,    fen: 1, nb: 1, be_last: 8'hFF, a_with_c: 0, exp_pass: 0};
    vecs[9] = '{dst: MATCH_MAC, et: MATCH_ET, fen: 1, nb: 1, be_last: 8'h00, a_with_c: 0, exp_pass: 1};

    ifc.iMatch_mac   = MATCH_MAC;
    ifc.iMatch_etype = MATCH_ET;
    ifc.iFilter_en   = 1'b1;
    clear();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    tick();
    rst = 1'b0;

    // Directed packet table
    for (int i = 0; i < 10; i++) begin
      ifc.iFilter_en = vecs[i].fen;
      send_pkt(vecs[i].dst, vecs[i].et, vecs[i].nb, vecs[i].be_last, vecs[i].a_with_c,
               K_NORMAL, vecs[i].exp_pass);
      check_counts($sformatf("vec%0d", i));
    end

    // Truncated passing packet, then a header-only runt, then a good packet
    ifc.iFilter_en = 1'b1;
    send_pkt(MATCH_MAC, MATCH_ET, 2, 8'hFF, 0, K_TRUNC, 1);
    send_pkt(MATCH_MAC, MATCH_ET, 0, 8'h00, 0, K_RUNT, 1);
    check_counts("trunc_runt");
    send_pkt(MATCH_MAC, MATCH_ET, 2, 8'h3F, 0, K_NORMAL, 1);
    check_counts("after_err");
    send_pkt(BCAST_MAC, MATCH_ET, 2, 8'hFF, 0, K_EARLY, 1);
    check_counts("early_payload");

    // Random packets
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0:       dst = MATCH_MAC;
        1:       dst = BCAST_MAC;
        default: dst = {16'($urandom), $urandom};
      endcase
      et  = ($urandom_range(0, 1) == 0) ? MATCH_ET : 16'($urandom);
      fen = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       kind = K_RUNT;
        1:       kind = K_EARLY;
        2:       kind = K_TRUNC;
        default: kind = K_NORMAL;
      endcase
      if (n == 59) kind = K_NORMAL;
      ifc.iFilter_en = fen;
      send_pkt(dst, et, $urandom_range(0, 4), 8'($urandom), 1'($urandom_range(0, 1)), kind,
               ref_pass(dst, et, fen));
      if (kind != K_TRUNC) check_counts($sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) begin tick(); clear(); end
    end

    // Reset in the middle of a forwarded payload
    ifc.iFilter_en = 1'b1;
    tick(); clear(); ifc.iSop = 1'b1;
    tick(); clear(); ifc.iHeader_A = MATCH_MAC; ifc.iHeader_A_valid = 1'b1;
    tick(); clear(); ifc.iHeader_B_valid = 1'b1;
    tick(); clear(); ifc.iHeader_C = MATCH_ET; ifc.iHeader_C_valid = 1'b1;
    tick(); clear(); ifc.iPayload_valid = 1'b1;
    tick(); clear(); ifc.iPayload_valid = 1'b1;
    chk("midrst.valid_before", ifc.oValid, 1'b1);
    chk("midrst.sop_before", ifc.oSop, 1'b1);
    rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    tick(); clear();
    tick();
    rst = 1'b0;
    pass_m = 0; drop_m = 0; err_m = 0;
    exp_q.delete();
    obs_q.delete();
    send_pkt(MATCH_MAC, MATCH_ET, 3, 8'h0F, 0, K_NORMAL, 1);
    check_counts("after_rst");

    // Twenty drops: the 4-bit copy must stick at 4'hF
    ifc.iFilter_en = 1'b1;
    for (int n = 0; n < 20; n++) begin
      send_pkt(MATCH_MAC, V6_ET, $urandom_range(0, 2), 8'hFF, 0, K_NORMAL, 0);
      check_counts($sformatf("sat%0d", n));
    end
    chk("sat.drop_cnt4_final", ifc4.oDrop_cnt, 4'hF);
    chk("sat.drop_cnt_final", ifc.oDrop_cnt, 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
